// File: rtl/display_frame_ctrl.sv
// Frame controller for a garbled-circuit display datapath: loads a message,
// takes one random word per frame, waits for the datapath to settle, then streams the pixels.
module display_frame_ctrl #(
   parameter int WIDTH       = 120,
   parameter int HEIGHT      = 52,
   parameter int RNDSIZE     = 9,
   parameter int NB_SEGMENTS = 70,
   parameter int OUT_W       = 32,
   parameter int DP_LATENCY  = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      msg_valid,
   output logic                      msg_ready,
   input  logic                      msg_z,
   input  logic [NB_SEGMENTS-1:0]    msg_seg,
   input  logic [15:0]               nb_frames,
   input  logic                      stop,
   input  logic                      rnd_valid,
   output logic                      rnd_ready,
   input  logic [RNDSIZE-1:0]        rnd_data,
   output logic                      dp_z,
   output logic [NB_SEGMENTS-1:0]    dp_msg,
   output logic [RNDSIZE-1:0]        dp_rnd,
   input  logic [WIDTH*HEIGHT-1:0]   dp_pix,
   output logic                      pix_valid,
   input  logic                      pix_ready,
   output logic [OUT_W-1:0]          pix_data,
   output logic                      pix_last,
   output logic                      busy,
   output logic [15:0]               frame_cnt
);

   localparam int NPIX     = WIDTH * HEIGHT;
   localparam int NB_WORDS = (NPIX + OUT_W - 1) / OUT_W;
   localparam int PADW     = NB_WORDS * OUT_W;
   localparam int IDX_W    = (NB_WORDS > 1) ? $clog2(NB_WORDS) : 1;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_RND = 2'd1,
      SETTLE   = 2'd2,
      STREAM   = 2'd3
   } state_t;

   state_t             state, state_n;
   logic [15:0]        budget;
   logic               unlimited;
   logic [IDX_W-1:0]   word_idx;
   logic [3:0]         settle_cnt;
   logic               stop_lat;
   logic [PADW-1:0]    pix_pad;
   logic               is_last;
   logic               budget_end;
   logic               msg_acc, rnd_acc, pix_acc, frame_done;

   assign is_last    = (word_idx == IDX_W'(NB_WORDS - 1));
   assign budget_end = !unlimited && (budget == 16'd1);
   assign msg_acc    = msg_valid && msg_ready;
   assign rnd_acc    = rnd_valid && rnd_ready;
   assign pix_acc    = pix_valid && pix_ready;
   assign frame_done = pix_acc && is_last;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // A pending stop suppresses rnd_ready so no random word is consumed on the way out.
   always_comb begin
      state_n   = state;
      msg_ready = 1'b0;
      rnd_ready = 1'b0;
      pix_valid = 1'b0;
      pix_last  = 1'b0;
      busy      = (state != IDLE);
      case (state)
         IDLE: begin
            msg_ready = 1'b1;
            if (msg_valid) state_n = WAIT_RND;
         end
         WAIT_RND: begin
            msg_ready = 1'b1;
            rnd_ready = !stop;
            if (stop)           state_n = IDLE;
            else if (rnd_valid) state_n = SETTLE;
         end
         SETTLE: begin
            if (stop)                                   state_n = IDLE;
            else if (settle_cnt == 4'(DP_LATENCY - 1))  state_n = STREAM;
         end
         STREAM: begin
            pix_valid = 1'b1;
            pix_last  = is_last;
            if (pix_ready && is_last)
               state_n = (budget_end || stop_lat || stop) ? IDLE : WAIT_RND;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dp_z       <= 1'b0;
         dp_msg     <= '0;
         dp_rnd     <= '0;
         budget     <= '0;
         unlimited  <= 1'b0;
         word_idx   <= '0;
         settle_cnt <= '0;
         stop_lat   <= 1'b0;
         frame_cnt  <= '0;
      end else begin
         if (msg_acc) begin
            dp_z      <= msg_z;
            dp_msg    <= msg_seg;
            budget    <= nb_frames;
            unlimited <= (nb_frames == 16'd0);
         end else if (frame_done && !unlimited) begin
            budget <= budget - 16'd1;
         end

         if (rnd_acc) begin
            dp_rnd     <= rnd_data;
            settle_cnt <= '0;
         end else if (state == SETTLE) begin
            settle_cnt <= settle_cnt + 4'd1;
         end

         if (state == SETTLE)
            word_idx <= '0;
         else if (pix_acc)
            word_idx <= is_last ? '0 : word_idx + IDX_W'(1);

         if (frame_done)
            frame_cnt <= frame_cnt + 16'd1;

         if (state_n == IDLE)
            stop_lat <= 1'b0;
         else if (state == STREAM && stop)
            stop_lat <= 1'b1;
      end
   end

   // Zero-extend the pixel vector so the final partial word reads 0 above the last pixel.
   always_comb begin
      pix_pad             = '0;
      pix_pad[NPIX-1:0]   = dp_pix;
      pix_data            = '0;
      for (int unsigned k = 0; k < NB_WORDS; k++)
         if (word_idx == IDX_W'(k))
            pix_data = pix_pad[k*OUT_W +: OUT_W];
   end

endmodule

// File: doc/display_frame_ctrl.md
DISPLAY_FRAME_CTRL -- requirements
Module: display_frame_ctrl

Interface
REQ-001 Parameter WIDTH, default 120, display width in pixels.
REQ-002 Parameter HEIGHT, default 52, display height in pixels.
REQ-003 Parameter RNDSIZE, default 9, width of the evaluator random word per frame.
REQ-004 Parameter NB_SEGMENTS, default 70, width of the message segment vector.
REQ-005 Parameter OUT_W, default 32, width of the output pixel word.
REQ-006 Parameter DP_LATENCY, default 2, settle cycles allowed for the display datapath after dp_rnd changes (1..15).
REQ-007 clk  in  1  single clock; all state updates on its rising edge.
REQ-008 rst  in  1  reset, synchronous and active-high.
REQ-009 msg_valid / msg_ready  in / out  1 / 1  message load handshake.
REQ-010 msg_z / msg_seg  in  1 / NB_SEGMENTS  garbler z bit and segment vector to load.
REQ-011 nb_frames  in  16  frames to render per loaded message, sampled at message acceptance; 0 = unlimited.
REQ-012 stop  in  1  request return to IDLE.
REQ-013 rnd_valid / rnd_ready  in / out  1 / 1  random word handshake, one word per frame.
REQ-014 rnd_data  in  RNDSIZE  random word.
REQ-015 dp_z / dp_msg / dp_rnd  out  1 / NB_SEGMENTS / RNDSIZE  registered drive of the display datapath inputs.
REQ-016 dp_pix  in  WIDTH*HEIGHT  datapath pixel result.
REQ-017 pix_valid / pix_ready  out / in  1 / 1  pixel word stream handshake.
REQ-018 pix_data / pix_last  out  OUT_W / 1  pixel word; pix_last marks the final word of a frame.
REQ-019 busy  out  1  high in any state other than IDLE.
REQ-020 frame_cnt  out  16  completed frames since reset, wraps 0xFFFF->0.

Function
REQ-021 The block SHALL be an FSM with states IDLE, WAIT_RND, SETTLE and STREAM.
REQ-022 A handshake occurs in a cycle where valid and ready are both high at the rising edge.
REQ-023 msg_ready SHALL be 1 in IDLE and WAIT_RND only; on acceptance, dp_z, dp_msg and the frame budget load from msg_z, msg_seg and nb_frames.
REQ-024 IDLE: on message acceptance, go to WAIT_RND.
REQ-025 WAIT_RND: rnd_ready=1; on rnd handshake, dp_rnd<=rnd_data, reset the settle counter, go to SETTLE.
REQ-026 Simultaneous msg and rnd handshakes in WAIT_RND: both take effect, so the frame uses the new message and the new rnd.
REQ-027 SETTLE: hold for exactly DP_LATENCY cycles, then go to STREAM with word index 0.
REQ-028 NB_WORDS = ceil(WIDTH*HEIGHT/OUT_W); word k = dp_pix bits [k*OUT_W +: OUT_W], and bits at or above WIDTH*HEIGHT SHALL read 0.
REQ-029 STREAM: pix_valid=1; pix_data and pix_last SHALL stay stable while pix_valid=1 and pix_ready=0.
REQ-030 pix_last=1 only when the word index = NB_WORDS-1; on each pix handshake, the index increments.
REQ-031 On the pix_last handshake: frame_cnt increments and the budget decrements (unless unlimited); go to IDLE if the budget reaches 0 or stop is latched, else go to WAIT_RND.
REQ-032 dp_z, dp_msg and dp_rnd SHALL NOT change in SETTLE or STREAM.
REQ-033 stop in WAIT_RND or SETTLE: go to IDLE next cycle with no pix words emitted.
REQ-034 stop in STREAM: latch it and finish the current frame; the latch clears on entry to IDLE.
REQ-035 stop in IDLE is ignored.
REQ-036 A message handshake in the same cycle as stop in WAIT_RND is accepted, then the block goes to IDLE.

Reset
REQ-037 While rst=1 at a clock edge, the FSM SHALL go to IDLE.
REQ-038 While rst=1 at a clock edge, these outputs SHALL be 0: dp_z, dp_msg, dp_rnd, frame_cnt, pix_valid, pix_last, rnd_ready, busy.
REQ-039 While rst=1 at a clock edge, the budget, word index, settle counter and stop latch SHALL clear.
REQ-040 msg_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-041 Reset mid-STREAM abandons the frame with no further pix_valid and no frame_cnt increment.

Verification (WIDTH=4, HEIGHT=3, OUT_W=8, DP_LATENCY=2)
REQ-042 Single frame:
- Stimulus: load msg with nb_frames=1, then rnd=0x1A5, with dp_pix=0xABC and pix_ready=1.
- Response: rnd_ready drops, then 2 SETTLE cycles, then words 0xBC and 0x0A with pix_last on the second, then IDLE with frame_cnt=1.
REQ-043 Backpressure:
- Stimulus: hold pix_ready=0 for 5 cycles on word 0.
- Response: pix_data stays 0xBC and pix_valid stays 1 throughout, with no index advance.
REQ-044 Multi-frame:
- Stimulus: nb_frames=3 with three rnd words.
- Response: three frames, each using its own dp_rnd; frame_cnt=3, then IDLE.
- Stimulus: nb_frames=0.
- Response: frames continue until stop.
REQ-045 Stop:
- Stimulus: stop in SETTLE.
- Response: IDLE next cycle with no pix words.
- Stimulus: stop during word 0 of STREAM.
- Response: word 1 with pix_last, then IDLE.
REQ-046 Message swap:
- Stimulus: msg and rnd handshakes in the same WAIT_RND cycle.
- Response: the frame is streamed with the new dp_msg.
REQ-047 Reset mid-STREAM:
- Stimulus: rst=1 during word 1.
- Response: all outputs 0, msg_ready=1 after release, frame_cnt unchanged at 0.
